// File: rtl/shake_squeeze.sv
// SHAKE256 squeeze stage: takes rate blocks from the permutation, emits them
// LSB-first as W-bit words, and asks for another permutation when a block runs out.
module shake_squeeze #(
  parameter int X     = 1088,
  parameter int W     = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] out_len,
  output logic             busy,
  input  logic [X-1:0]     blk_data,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             perm_req,
  output logic [W-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             done
);

  localparam int WPB   = X / W;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

  if (X % W != 0) begin : g_bad_rate
    $error("shake_squeeze: X (%0d) must be a multiple of W (%0d)", X, W);
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    EMIT,
    REQ,
    DONE
  } state_t;

  state_t             state, state_nx;
  logic [X-1:0]       blk_buf;
  logic [IDX_W-1:0]   idx;
  logic [LEN_W-1:0]   rem;
  logic [W-1:0]       words [WPB];

  logic               out_hs;
  logic               last_word;
  logic               block_end;

  always_comb begin
    for (int k = 0; k < WPB; k++) begin
      words[k] = blk_buf[k*W +: W];
    end
  end

  assign out_hs    = (state == EMIT) && dout_ready;
  assign last_word = (rem == LEN_W'(1));
  assign block_end = (idx == IDX_W'(WPB - 1));

  // NOTE: every output and next-state value gets a default before the case so
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    blk_ready  = 1'b0;
    perm_req   = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          // The first block is the post-absorb permutation output, so no request here.
          state_nx = (out_len != '0) ? WAIT_BLK : DONE;
        end
      end
      WAIT_BLK: begin
        blk_ready = 1'b1;
        if (blk_valid) state_nx = EMIT;
      end
      EMIT: begin
        dout_valid = 1'b1;
        dout_last  = last_word;
        if (out_hs) begin
          // Job end wins over block end: an exact-boundary job requests nothing.
          if (last_word)      state_nx = DONE;
          else if (block_end) state_nx = REQ;
        end
      end
      REQ: begin
        perm_req = 1'b1;
        state_nx = WAIT_BLK;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dout = dout_valid ? words[idx] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      blk_buf <= '0;
      idx     <= '0;
      rem     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start && out_len != '0) rem <= out_len;
        end
        WAIT_BLK: begin
          if (blk_valid) begin
            blk_buf <= blk_data;
            idx     <= '0;
          end
        end
        EMIT: begin
          if (out_hs) begin
            rem <= rem - LEN_W'(1);
            idx <= block_end ? '0 : idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_squeeze.sv
// Directed bench for shake_squeeze: table of squeeze jobs driven through a
// generic job runner, plus hand sequences for ignored inputs and mid-job reset.
module tb_shake_squeeze;

  localparam int X     = 1088;
  localparam int W     = 64;
  localparam int LEN_W = 16;
  localparam int WPB   = X / W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] out_len;
  logic             busy;
  logic [X-1:0]     blk_data;
  logic             blk_valid;
  logic             blk_ready;
  logic             perm_req;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             done;

  int errors = 0;
  int checks = 0;

  shake_squeeze #(.X(X), .W(W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .out_len(out_len), .busy(busy),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .perm_req(perm_req), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Block b carries word k = 100*b + k.
  function automatic logic [X-1:0] make_block(input int b);
    logic [X-1:0] blk;
    for (int k = 0; k < WPB; k++) blk[k*W +: W] = 64'(b * 100 + k);
    return blk;
  endfunction

  function automatic logic [W-1:0] exp_word(input int n);
    return 64'((n / WPB) * 100 + (n % WPB));
  endfunction

  typedef struct {
    int         len;
    logic [7:0] rpat;       // dout_ready pattern, bit i used on the i-th valid cycle (mod 8)
    int         exp_perm;
    int         exp_blocks;
  } vec_t;

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_blk_ready"},  blk_ready,  0);
    check({tag, "_perm_req"},   perm_req,   0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_dout_last"},  dout_last,  0);
    check({tag, "_done"},       done,       0);
    check({tag, "_dout"},       dout,       0);
  endtask

  // Starts and ends at a negedge; inputs are driven and outputs sampled there.
  task automatic run_job(input vec_t v);
    int n = 0, p = 0, blk_cnt = 0, perm_cnt = 0, cyc = 0;
    bit last_acc = 0, blk_end_acc = 0, blk_taken = 0, fin = 0, prev_stall = 0;
    logic [W-1:0] prev_dout = '0;
    logic prev_last = 0;
    start = 1; out_len = LEN_W'(v.len);
    @(negedge clk);
    start = 0;
    if (v.len == 0) begin
      check("zero_done",       done,       1);
      check("zero_busy",       busy,       1);
      check("zero_dout_valid", dout_valid, 0);
      check("zero_blk_ready",  blk_ready,  0);
      @(negedge clk);
      check("zero_idle_busy",  busy, 0);
      check("zero_idle_done",  done, 0);
      return;
    end
    check("start_busy",      busy,      1);
    check("start_blk_ready", blk_ready, 1);
    while (!fin && cyc < 2000) begin
      check("perm_req_timing", perm_req, blk_end_acc);
      if (perm_req) perm_cnt++;
      if (blk_taken) check("first_word_latency", dout_valid, 1);
      if (prev_stall) begin
        check("stall_valid", dout_valid, 1);
        check("stall_dout",  dout,       prev_dout);
        check("stall_last",  dout_last,  prev_last);
      end
      if (last_acc) begin
        check("done_pulse", done, 1);
        check("done_busy",  busy, 1);
        fin = 1;
      end else if (done) begin
        check("early_done", done, 0);
      end
      blk_taken = 0; last_acc = 0; blk_end_acc = 0; prev_stall = 0;
      blk_valid = 0; dout_ready = 0;
      if (!fin) begin
        if (blk_ready) begin
          blk_valid = 1;
          blk_data  = make_block(blk_cnt);
          blk_cnt++;
          blk_taken = 1;
        end
        if (dout_valid) begin
          check("dout",      dout,      exp_word(n));
          check("dout_last", dout_last, (n == v.len - 1));
          dout_ready = v.rpat[p % 8];
          p++;
          prev_dout = dout; prev_last = dout_last;
          if (dout_ready) begin
            n++;
            if (n == v.len)      last_acc = 1;
            else if (n % WPB == 0) blk_end_acc = 1;
          end else begin
            prev_stall = 1;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check("job_timeout", 1, 0);
    @(negedge clk);
    check("end_busy",   busy,       0);
    check("end_done",   done,       0);
    check("end_valid",  dout_valid, 0);
    check("word_count", n,          v.len);
    check("perm_count", perm_cnt,   v.exp_perm);
    check("blk_count",  blk_cnt,    v.exp_blocks);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 3,  rpat: 8'hFF, exp_perm: 0, exp_blocks: 1};
    vecs[1] = '{len: 17, rpat: 8'hFF, exp_perm: 0, exp_blocks: 1};
    vecs[2] = '{len: 20, rpat: 8'hFF, exp_perm: 1, exp_blocks: 2};
    vecs[3] = '{len: 5,  rpat: 8'hE9, exp_perm: 0, exp_blocks: 1};  // 1,0,0,1,0,1,1,1
    vecs[4] = '{len: 0,  rpat: 8'hFF, exp_perm: 0, exp_blocks: 0};
    vecs[5] = '{len: 35, rpat: 8'h5B, exp_perm: 2, exp_blocks: 3};
    vecs[6] = '{len: 1,  rpat: 8'hFF, exp_perm: 0, exp_blocks: 1};

    rst = 1; start = 0; out_len = '0; blk_data = '0; blk_valid = 0; dout_ready = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // start and blk_valid while emitting must be ignored.
    start = 1; out_len = 3;
    @(negedge clk);
    start = 0;
    check("ign_blk_ready", blk_ready, 1);
    blk_valid = 1; blk_data = make_block(0);
    @(negedge clk);
    blk_valid = 0;
    check("ign_valid", dout_valid, 1);
    start = 1; out_len = 9; blk_valid = 1; blk_data = make_block(5); dout_ready = 0;
    @(negedge clk);
    check("ign_blk_ready_emit", blk_ready, 0);
    check("ign_busy",           busy,      1);
    start = 0; blk_valid = 0; dout_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("ign_word_valid", dout_valid, 1);
      check("ign_word",       dout,       64'(i));
      check("ign_word_last",  dout_last,  (i == 2));
      @(negedge clk);
    end
    check("ign_done", done, 1);
    dout_ready = 0;
    @(negedge clk);
    check("ign_idle_busy",      busy,      0);
    check("ign_idle_blk_ready", blk_ready, 0);

    // Reset in the middle of a 20-word job, then a fresh 2-word job.
    start = 1; out_len = 20;
    @(negedge clk);
    start = 0; blk_valid = 1; blk_data = make_block(0);
    @(negedge clk);
    blk_valid = 0; dout_ready = 1;
    repeat (5) @(negedge clk);
    check("pre_reset_word", dout, 5);
    rst = 1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 0; dout_ready = 0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    run_job('{len: 2, rpat: 8'hFF, exp_perm: 0, exp_blocks: 1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
